// File: rtl/frame_buf_owner_sched.sv
// Frame-buffer write-port ownership scheduler: alternates the shared BRAM write
// port between the camera capture writer and the Gaussian filter writer.
module frame_buf_owner_sched #(
    parameter int unsigned FRAME_PIXELS   = 76800,
    parameter int unsigned ADDR_W         = 18,
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cam_vsync,
    input  logic              cam_wea,
    input  logic              gauss_done,
    output logic              mux_ctrl,
    output logic              cam_capture_en,
    output logic              gauss_start,
    output logic [ADDR_W-1:0] pix_count,
    output logic [15:0]       frame_done_cnt,
    output logic [7:0]        drop_cnt,
    output logic              timeout_err,
    output logic [2:0]        state_dbg
);

    localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [GW-1:0]     GUARD_LAST   = GW'(GUARD_CYCLES - 1);
    localparam logic [TW-1:0]     TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST     = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        GUARD_C = 3'd2,
        FILTER  = 3'd3,
        GUARD_G = 3'd4
    } stateT;

    stateT         state;
    stateT         nextState;
    logic          vsyncQ;
    logic          vsyncEdge;
    logic          frameLast;
    logic [GW-1:0] guardCnt;
    logic [TW-1:0] toCnt;
    logic          guardDone;
    logic          timedOut;
    logic          filterOk;
    logic          muxNext;
    logic          capEnNext;
    logic          gaussStartNext;

    assign vsyncEdge = cam_vsync & ~vsyncQ;
    assign frameLast = cam_wea && (pix_count == PIX_LAST);
    assign guardDone = (guardCnt == GUARD_LAST);
    assign timedOut  = (toCnt == TIMEOUT_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (vsyncEdge && enable) nextState = CAPTURE;
            // A completing strobe wins over both enable loss and a new vsync.
            CAPTURE: begin
                if (frameLast)    nextState = GUARD_C;
                else if (!enable) nextState = IDLE;
            end
            GUARD_C: if (guardDone) nextState = FILTER;
            FILTER:  if (gauss_done || timedOut) nextState = GUARD_G;
            GUARD_G: if (guardDone) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so they register in step with it.
    always_comb begin
        muxNext        = (nextState == IDLE) || (nextState == CAPTURE) || (nextState == GUARD_C);
        capEnNext      = (nextState == CAPTURE);
        gaussStartNext = (state == GUARD_C) && (nextState == FILTER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_ctrl       <= 1'b1;
            cam_capture_en <= 1'b0;
            gauss_start    <= 1'b0;
        end else begin
            mux_ctrl       <= muxNext;
            cam_capture_en <= capEnNext;
            gauss_start    <= gaussStartNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsyncQ   <= 1'b0;
            guardCnt <= '0;
            toCnt    <= '0;
        end else begin
            vsyncQ <= cam_vsync;
            if ((state == GUARD_C || state == GUARD_G) && nextState == state) begin
                guardCnt <= guardCnt + 1'b1;
            end else begin
                guardCnt <= '0;
            end
            if (state == FILTER && nextState == FILTER) begin
                toCnt <= toCnt + 1'b1;
            end else begin
                toCnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_count <= '0;
        end else begin
            case (state)
                IDLE: if (vsyncEdge && enable) pix_count <= '0;
                CAPTURE: begin
                    if (frameLast)      pix_count <= pix_count + 1'b1;
                    else if (!enable)   pix_count <= '0;
                    else if (vsyncEdge) pix_count <= '0;
                    else if (cam_wea)   pix_count <= pix_count + 1'b1;
                end
                default: pix_count <= pix_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt       <= '0;
            frame_done_cnt <= '0;
            timeout_err    <= 1'b0;
            filterOk       <= 1'b0;
        end else begin
            if (vsyncEdge && drop_cnt != '1 &&
                ((state == CAPTURE && enable && !frameLast) ||
                 state == GUARD_C || state == FILTER || state == GUARD_G)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (state == FILTER && nextState == GUARD_G) begin
                filterOk <= gauss_done;
                if (!gauss_done) timeout_err <= 1'b1;
            end
            if (state == GUARD_G && guardDone && filterOk && frame_done_cnt != '1) begin
                frame_done_cnt <= frame_done_cnt + 1'b1;
            end
        end
    end

endmodule
